// File: rtl/servo_slew_controller.sv
// servo_slew_controller
//   Slew-rate-limited servo pulse-width commander. Button and sweep inputs
//   are synchronised and debounced. Requests pick a target width, and the
//   commanded width moves toward that target by at most STEP per servo
//   frame. Width updates only happen at frame boundaries.
// Ports:
//   CLK, RST          - clock (rising edge), asynchronous active-high reset
//   BTNL, BTNC, BTNR  - raw buttons requesting left / neutral / right
//   SWEEP             - raw switch; high runs a continuous L<->R sweep
//   width             - commanded pulse width (18 bits) to the PWM stage
//   frame_start       - one-cycle strobe at each frame boundary
//   busy              - high while the FSM is not IDLE
//   LEDS              - one-hot target indicator: [2]=L, [1]=N, [0]=R
module servo_slew_controller #(
  parameter logic [18:0] PERIOD_CNT = 19'h7FFFE,
  parameter logic [17:0] STEP       = 18'h00400,
  parameter logic [19:0] DB_CYCLES  = 20'd1_000_000,
  parameter logic [17:0] L_W        = 18'h0D6D8,
  parameter logic [17:0] N_W        = 18'h124F8,
  parameter logic [17:0] R_W        = 18'h17318
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTNL,
  input  logic        BTNC,
  input  logic        BTNR,
  input  logic        SWEEP,
  output logic [17:0] width,
  output logic        frame_start,
  output logic        busy,
  output logic [2:0]  LEDS
);

  typedef enum logic [1:0] {IDLE, SLEW, SWP_R, SWP_L} state_t;

  state_t      state;
  logic [17:0] target;

  // Channel order: 0=L, 1=C, 2=R, 3=SWEEP
  logic [3:0]  raw;
  logic [3:0]  sync1, sync2;
  logic [3:0]  level, level_q;
  logic [19:0] db_cnt [4];
  logic [3:0]  rise, fall;

  assign raw  = {SWEEP, BTNR, BTNC, BTNL};
  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

  // Any cycle where the synchronised input matches the debounced level
  // clears the run counter, so only an uninterrupted run of DB_CYCLES
  // differing cycles moves the level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 20'd1) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Slew step in 19 bits so neither direction can wrap before clamping.
  logic [18:0] w19, t19, up, dn;
  logic [17:0] slew_next;

  always_comb begin
    w19       = {1'b0, width};
    t19       = {1'b0, target};
    up        = w19 + {1'b0, STEP};
    dn        = w19 - {1'b0, STEP};
    slew_next = width;
    if (w19 < t19) begin
      slew_next = (up >= t19) ? target : up[17:0];
    end else if (w19 > t19) begin
      slew_next = (dn[18] || dn <= t19) ? target : dn[17:0];
    end
  end

  // Width is loaded on the same edge that raises frame_start, so its new
  // value is visible exactly in the frame_start cycle.
  logic [18:0] frame_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      width       <= N_W;
    end else if (frame_cnt == PERIOD_CNT - 19'd1) begin
      frame_cnt   <= '0;
      frame_start <= 1'b1;
      width       <= slew_next;
    end else begin
      frame_cnt   <= frame_cnt + 19'd1;
      frame_start <= 1'b0;
    end
  end

  // Button priority C > L > R.
  logic        req_any;
  logic [17:0] req_tgt;

  always_comb begin
    req_any = |rise[2:0];
    req_tgt = R_W;
    if (rise[1])      req_tgt = N_W;
    else if (rise[0]) req_tgt = L_W;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      target <= N_W;
    end else if (rise[3]) begin
      state  <= SWP_R;
      target <= R_W;
    end else if (fall[3]) begin
      state  <= SLEW;
      target <= N_W;
    end else begin
      case (state)
        IDLE, SLEW: begin
          if (req_any && req_tgt != target) begin
            target <= req_tgt;
            state  <= SLEW;
          end else if (state == SLEW && width == target) begin
            state <= IDLE;
          end
        end
        SWP_R: begin
          if (width == R_W) begin
            state  <= SWP_L;
            target <= L_W;
          end
        end
        SWP_L: begin
          if (width == L_W) begin
            state  <= SWP_R;
            target <= R_W;
          end
        end
        default: begin
          state  <= IDLE;
          target <= N_W;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    LEDS = 3'b010;
    if (target == L_W)      LEDS = 3'b100;
    else if (target == R_W) LEDS = 3'b001;
  end

endmodule

// File: tb/tb_servo_slew_controller.sv
// tb_servo_slew_controller
//   Directed bench for servo_slew_controller with PERIOD_CNT=100,
//   STEP=0x1000 and DB_CYCLES=4. Inputs change on the falling clock edge,
//   and outputs are sampled on falling edges (or just after an asynchronous
//   reset assertion).
module tb_servo_slew_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        BTNL = 1'b0, BTNC = 1'b0, BTNR = 1'b0, SWEEP = 1'b0;
  logic [17:0] width;
  logic        frame_start;
  logic        busy;
  logic [2:0]  LEDS;

  int tests = 0;
  int fails = 0;

  servo_slew_controller #(
    .PERIOD_CNT (19'd100),
    .STEP       (18'h01000),
    .DB_CYCLES  (20'd4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BTNL        (BTNL),
    .BTNC        (BTNC),
    .BTNR        (BTNR),
    .SWEEP       (SWEEP),
    .width       (width),
    .frame_start (frame_start),
    .busy        (busy),
    .LEDS        (LEDS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Bounded wait for the next frame strobe, then check the width it carries.
  task automatic frame_width(input string tag, input logic [17:0] exp);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_start && n < 300);
    check({tag, " strobe"}, {31'd0, frame_start}, 32'd1);
    check(tag, {14'd0, width}, {14'd0, exp});
  endtask

  // Release reset on a falling edge and expect the first strobe 100 cycles later.
  task automatic release_and_time_frame(input string tag);
    logic early = 1'b0;
    RST = 1'b0;
    repeat (99) begin
      @(negedge CLK);
      if (frame_start) early = 1'b1;
    end
    check({tag, " no early strobe"}, {31'd0, early}, 32'd0);
    @(negedge CLK);
    check({tag, " strobe at 100"}, {31'd0, frame_start}, 32'd1);
  endtask

  initial begin
    // Reset visible before any clock edge
    #2 RST = 1'b1;
    #1;
    check("rst width", {14'd0, width}, 32'h124F8);
    check("rst leds", {29'd0, LEDS}, 32'b010);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst frame_start", {31'd0, frame_start}, 32'd0);
    cycles(3);
    release_and_time_frame("first frame");

    // Hold BTNL: slew N -> L over five frames
    BTNL = 1'b1; cycles(10); BTNL = 1'b0;
    check("L leds", {29'd0, LEDS}, 32'b100);
    check("L busy", {31'd0, busy}, 32'd1);
    frame_width("L f1", 18'h114F8);
    frame_width("L f2", 18'h104F8);
    frame_width("L f3", 18'h0F4F8);
    frame_width("L f4", 18'h0E4F8);
    frame_width("L f5", 18'h0D6D8);
    check("L busy at arrival", {31'd0, busy}, 32'd1);
    cycles(1);
    check("L idle after", {31'd0, busy}, 32'd0);

    // Two-cycle BTNR glitch is rejected
    BTNR = 1'b1; cycles(2); BTNR = 1'b0; cycles(10);
    check("glitch width", {14'd0, width}, 32'h0D6D8);
    check("glitch leds", {29'd0, LEDS}, 32'b100);
    check("glitch busy", {31'd0, busy}, 32'd0);

    // L and R together: L wins, R discarded
    BTNL = 1'b1; BTNR = 1'b1; cycles(10); BTNL = 1'b0; BTNR = 1'b0; cycles(2);
    check("L+R leds", {29'd0, LEDS}, 32'b100);
    check("L+R busy", {31'd0, busy}, 32'd0);
    frame_width("L+R hold", 18'h0D6D8);

    // C and R together: C wins; then retarget to R mid-slew
    BTNC = 1'b1; BTNR = 1'b1; cycles(10); BTNC = 1'b0; BTNR = 1'b0;
    check("C+R leds", {29'd0, LEDS}, 32'b010);
    check("C+R busy", {31'd0, busy}, 32'd1);
    frame_width("C f1", 18'h0E6D8);
    BTNR = 1'b1; cycles(10); BTNR = 1'b0;
    check("retarget leds", {29'd0, LEDS}, 32'b001);
    check("retarget busy", {31'd0, busy}, 32'd1);
    frame_width("R f1", 18'h0F6D8);

    // Reset mid-slew
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst width", {14'd0, width}, 32'h124F8);
    check("midrst leds", {29'd0, LEDS}, 32'b010);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst frame_start", {31'd0, frame_start}, 32'd0);
    cycles(2);
    release_and_time_frame("post-rst frame");
    check("post-rst width", {14'd0, width}, 32'h124F8);
    check("post-rst busy", {31'd0, busy}, 32'd0);

    // Sweep: ramp to R, reverse toward L, buttons ignored
    SWEEP = 1'b1; cycles(10);
    check("sweep leds R", {29'd0, LEDS}, 32'b001);
    check("sweep busy", {31'd0, busy}, 32'd1);
    BTNC = 1'b1; cycles(10); BTNC = 1'b0;
    check("sweep ignores C", {29'd0, LEDS}, 32'b001);
    frame_width("sw f1", 18'h134F8);
    frame_width("sw f2", 18'h144F8);
    frame_width("sw f3", 18'h154F8);
    frame_width("sw f4", 18'h164F8);
    frame_width("sw f5", 18'h17318);
    cycles(1);
    check("sweep reverse leds", {29'd0, LEDS}, 32'b100);
    frame_width("sw f6", 18'h16318);

    // Sweep off: return to neutral, then idle
    SWEEP = 1'b0; cycles(10);
    check("unsweep leds", {29'd0, LEDS}, 32'b010);
    check("unsweep busy", {31'd0, busy}, 32'd1);
    frame_width("ret f1", 18'h15318);
    frame_width("ret f2", 18'h14318);
    frame_width("ret f3", 18'h13318);
    frame_width("ret f4", 18'h124F8);
    cycles(1);
    check("ret idle", {31'd0, busy}, 32'd0);
    check("ret leds", {29'd0, LEDS}, 32'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/servo_slew_controller.md
SERVO_SLEW_CONTROLLER -- requirements
Module: servo_slew_controller

Interface
REQ-001 Parameter PERIOD_CNT, default 19'h7FFFE, servo frame length in CLK cycles.
REQ-002 Parameter STEP, default 18'h00400, maximum pulse-width change per frame.
REQ-003 Parameter DB_CYCLES, default 20'd1_000_000, debounce stability time in cycles.
REQ-004 Parameters L_W, N_W and R_W, defaults 18'h0D6D8, 18'h124F8 and 18'h17318, give the left, neutral and right pulse widths.
REQ-005 Port CLK, input, 1 bit, system clock; all state is on the rising edge.
REQ-006 Port RST, input, 1 bit, reset; asynchronous, active-high.
REQ-007 Ports BTNL, BTNC and BTNR, inputs, 1 bit each, raw asynchronous buttons requesting left, neutral and right.
REQ-008 Port SWEEP, input, 1 bit, raw switch; high enables continuous L<->R sweep.
REQ-009 Port width, output, 18 bits, commanded pulse width to the PWM generator.
REQ-010 Port frame_start, output, 1 bit, one-cycle strobe at each frame boundary.
REQ-011 Port busy, output, 1 bit, high while the state is not IDLE.
REQ-012 Port LEDS, output, 3 bits, one-hot target indicator: [2]=L, [1]=N, [0]=R.

Function
REQ-013 Each of BTNL, BTNC, BTNR and SWEEP shall pass through a 2-FF synchronizer, then a debouncer.
REQ-014 A debounced level shall change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any shorter glitch shall be ignored.
REQ-015 A button request shall be the single-cycle rising edge of its debounced level.
REQ-016 Frame counter: counts 0..PERIOD_CNT-1 and wraps to 0; frame_start=1 in the cycle after the counter wraps to 0.
REQ-017 width shall change only in the cycle frame_start=1, so width never changes mid-frame.
REQ-018 Slew rule at frame_start: if width<target, width=min(width+STEP,target); if width>target, width=max(width-STEP,target).
REQ-019 Slew arithmetic shall use 19 bits; the result shall never overshoot target or leave [L_W,R_W].
REQ-020 FSM states: IDLE (width==target), SLEW (width!=target), SWP_R (target=R_W) and SWP_L (target=L_W).
REQ-021 In IDLE or SLEW, a request sets target: C->N_W, L->L_W, R->R_W.
REQ-022 Simultaneous requests shall be resolved by priority C > L > R.
REQ-023 A request during SLEW shall retarget immediately; slewing continues from the current width.
REQ-024 SLEW->IDLE in the cycle after width reaches target.
REQ-025 IDLE->SLEW in the cycle after a request whose target differs from width.
REQ-026 A request equal to the current target shall leave the state unchanged.
REQ-027 Debounced SWEEP rising edge from any state: go to SWP_R.
REQ-028 SWP_R->SWP_L when width==R_W; SWP_L->SWP_R when width==L_W.
REQ-029 Button requests shall be ignored in SWP_R and SWP_L.
REQ-030 Debounced SWEEP falling edge: target=N_W, go to SLEW.
REQ-031 LEDS shall decode target combinationally; exactly one bit is set at all times.

Reset
REQ-032 While RST=1, regardless of CLK: width=N_W, target=N_W, state=IDLE, frame counter=0, frame_start=0, busy=0, LEDS=3'b010.
REQ-033 While RST=1, debouncer counters, debounced levels and synchronizers shall be 0.
REQ-034 After RST falls, the first frame_start shall occur PERIOD_CNT cycles later.
REQ-035 RST asserted mid-slew shall abandon the slew with no further width update.

Verification (PERIOD_CNT=100, STEP=18'h01000, DB_CYCLES=4)
REQ-036 Reset: assert RST -> width=0x124F8, LEDS=010, busy=0, frame_start=0 with no clock edge needed.
REQ-037 BTNL held 10 cycles -> LEDS=100, busy=1; width at successive frame_starts: 0x114F8, 0x104F8, 0x0F4F8, 0x0E4F8, 0x0D6D8; busy=0 the cycle after.
REQ-038 BTNL and BTNR rise in the same cycle and are held -> target=L_W (LEDS=100); the R request is discarded.
REQ-039 BTNR pulsed for 2 cycles -> no request; width, LEDS and busy unchanged.
REQ-040 SWEEP=1 -> width ramps to 0x17318, then reverses toward 0x0D6D8; buttons ignored; SWEEP=0 -> returns to 0x124F8, then IDLE.
REQ-041 RST pulsed mid-slew from N to R -> width=0x124F8 immediately; frame counter restarts; the next frame_start occurs 100 cycles after RST falls.
